// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Registered ALU with valid/ready handshake, flag register and shift-add multiplier
//
// Purpose:
//   Registered successor of the 16-bit combinational ALU. Accepts one operation
//   at a time over a valid/ready handshake and holds the result, the MUL upper
//   half and the {Z,S,C,V} flag register until the consumer takes them.
//   Single-cycle ops complete one edge after accept. MUL runs a WIDTH-step
//   shift-add sequence before completing.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands/opcode valid
//   in_ready   out  1      block can accept an operation this cycle
//   opcode     in   4      operation select
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount (b[SHW-1:0])
//   out_valid  out  1      result/result_hi/flags valid
//   out_ready  in   1      consumer takes result this cycle
//   result     out  WIDTH  result
//   result_hi  out  WIDTH  MUL upper half, 0 for every other op
//   flags      out  4      {Z,S,C,V} flag register

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_ADC = 4'h6;
  localparam logic [3:0] OP_SBB = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  localparam int FLAG_C = 1;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic [3:0]         r_flags;

  // Shift-add multiplier datapath
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_cin;
  logic [WIDTH-1:0]   w_out;
  logic [3:0]         w_flags;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   w_prod_hi;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags     = r_flags;

  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = b[SHW-1:0];

  // Single-cycle datapath. Arithmetic runs in WIDTH+1 bits so bit WIDTH is
  // the carry (add) or borrow (subtract). Shifts park the last bit shifted
  // out in the extra bit so the carry falls out of the same vector.
  // ADC/SBB take the carry straight from the flag register: that is the
  // previous op's carry even when the new op is accepted in the DONE cycle.
  always_comb begin
    w_ext = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_cin = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        w_cin = (opcode == OP_ADC) ? r_flags[FLAG_C] : 1'b0;
        w_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        w_cin = (opcode == OP_SBB) ? r_flags[FLAG_C] : 1'b0;
        w_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: begin
        w_ext = {1'b0, a} << w_shamt;
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
      end
      OP_SHR: begin
        w_ext = {a, 1'b0} >> w_shamt;
        w_res = w_ext[WIDTH:1];
        w_c   = w_ext[0];
      end
      OP_SAR: begin
        w_ext = $unsigned($signed({a, 1'b0}) >>> w_shamt);
        w_res = w_ext[WIDTH:1];
        w_c   = w_ext[0];
      end
      default: begin
        // Undefined opcodes (and MUL, which never uses this path) give 0.
        w_res = '0;
      end
    endcase
  end

  // CMP reports the subtraction flags but passes A through as the result.
  assign w_flags = {(w_res == '0), w_res[MSB], w_c, w_v};
  assign w_out   = (opcode == OP_CMP) ? a : w_res;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_hi   = w_prod_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (opcode == OP_MUL) begin
              r_state  <= S_BUSY;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_prod   <= '0;
              r_cnt    <= CNT_INIT;
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_out;
              r_result_hi <= '0;
              r_flags     <= w_flags;
            end
          end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_prod   <= w_prod_next;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - CNT_LAST;
          // The last step's sum is written straight to the outputs so DONE
          // follows exactly WIDTH busy cycles.
          if (r_cnt == CNT_LAST) begin
            r_state     <= S_DONE;
            r_result    <= w_prod_next[WIDTH-1:0];
            r_result_hi <= w_prod_hi;
            r_flags     <= {(w_prod_next == '0), w_prod_next[MSB],
                            (w_prod_hi != '0), (w_prod_hi != '0)};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - Scoreboard testbench for alu_seq

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic [3:0]  flags;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  logic m_c = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x,
                                 input logic [15:0] y, input logic cin);
    exp_t        e;
    int unsigned s;
    int          d;
    logic [15:0] r;
    logic [31:0] p;
    logic        c;
    logic        v;
    int          n;
    e.hi = '0;
    r = '0; p = '0; c = 1'b0; v = 1'b0;
    n = int'(y[3:0]);
    case (op)
      4'h0, 4'h6: begin
        s = 32'(x) + 32'(y) + 32'((op == 4'h6) & cin);
        r = s[15:0];
        c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      4'h1, 4'h7, 4'hC: begin
        d = int'(x) - int'(y) - ((op == 4'h7) ? int'(cin) : 0);
        r = d[15:0];
        c = (d < 0);
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = ~x;
      4'h8: begin
        r = x;
        for (int i = 0; i < n; i++) begin c = r[15]; r = r << 1; end
      end
      4'h9: begin
        r = x;
        for (int i = 0; i < n; i++) begin c = r[0]; r = r >> 1; end
      end
      4'hA: begin
        r = x;
        for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
      end
      4'hB: begin
        p = 32'(x) * 32'(y);
        r = p[15:0];
        e.hi = p[31:16];
        c = (e.hi != 0);
        v = c;
      end
      default: r = '0;
    endcase
    e.fl  = {(op == 4'hB) ? (p == 0) : (r == 0), r[15], c, v};
    e.res = (op == 4'hC) ? x : r;
    return e;
  endfunction

  // Drive one op; push its expected outcome at the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    exp_t e;
    int   t;
    t = 0;
    opcode = op; a = ia; b = ib; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    e = model(op, ia, ib, m_c);
    sb.push_back(e);
    m_c = e.fl[1];
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_result_hi", 32'(result_hi), 32'(e.hi));
        check("sb_flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    int nrdy;
    int seen;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_result_hi", 32'(result_hi), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed overflow, latency 1
    issue(4'h0, 16'h7FFF, 16'h0001);
    check("add_ovf_valid", 32'(out_valid), 32'd1);
    check("add_ovf_res", 32'(result), 32'h8000);
    check("add_ovf_flags", 32'(flags), 32'b0101);

    // Carry chain back-to-back
    issue(4'h0, 16'hFFFF, 16'h0001);
    check("add_carry_res", 32'(result), 32'h0000);
    check("add_carry_flags", 32'(flags), 32'b1010);
    issue(4'h6, 16'h0000, 16'h0000);
    check("adc_res", 32'(result), 32'h0001);
    check("adc_flags", 32'(flags), 32'b0000);

    issue(4'h1, 16'h0003, 16'h0005);
    check("sub_res", 32'(result), 32'hFFFE);
    check("sub_flags", 32'(flags), 32'b0110);
    issue(4'hC, 16'h0005, 16'h0005);
    check("cmp_res", 32'(result), 32'h0005);
    check("cmp_flags", 32'(flags), 32'b1000);
    issue(4'hA, 16'h8001, 16'h0001);
    check("sar_res", 32'(result), 32'hC000);
    check("sar_flags", 32'(flags), 32'b0110);
    issue(4'h8, 16'h1234, 16'h0000);
    check("shl0_res", 32'(result), 32'h1234);
    check("shl0_flags", 32'(flags), 32'b0000);
    issue(4'hE, 16'h1234, 16'h5678);
    check("undef_res", 32'(result), 32'h0000);
    check("undef_flags", 32'(flags), 32'b1000);

    // Multiplier latency
    issue(4'hB, 16'h1234, 16'h0100);
    nv = 0; nrdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      nv++;
      if (!in_ready) nrdy++;
    end
    check("mul_latency", 32'(nv), 32'd16);
    check("mul_busy_in_ready_low", 32'(nrdy), 32'd16);
    check("mul_res", 32'(result), 32'h3400);
    check("mul_hi", 32'(result_hi), 32'h0012);
    check("mul_flags", 32'(flags), 32'b0011);
    @(posedge clk); #1;

    // Back-pressure: outputs held while out_ready low
    out_ready = 1'b0;
    issue(4'h0, 16'h1111, 16'h2222);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_res", 32'(result), 32'h3333);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(4'h1, 16'h0000, 16'h0001);
    issue(4'hB, 16'hFFFF, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmul_out_valid", 32'(out_valid), 32'd0);
    check("rstmul_flags", 32'(flags), 32'd0);
    check("rstmul_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstmul_quiet", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Random traffic through the scoreboard
    for (int k = 0; k < 80; k++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
